// File: rtl/seq_detector_prog_pkg.sv
// rtl/seq_detector_prog_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_detector_prog_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HUNT = 1'b1
   } state_e;

   localparam int unsigned MASK_W = 32;

   function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
      return (len >= 32'd1) && (len <= max_len);
   endfunction

   // Callers truncate the result to their own pattern width.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      if (len >= MASK_W) begin
         m = '1;
      end else begin
         m = (32'd1 << len) - 32'd1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_detector_prog_mask_cmp.sv
// rtl/seq_detector_prog_mask_cmp.sv - masked compare of the candidate history window against the pattern
module seq_mask_cmp
   import seq_detector_prog_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN-1:0] hist_n,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               hit_raw
);

   logic [MAX_LEN-1:0] mask;

   always_comb begin
      mask    = MAX_LEN'(len_mask(32'(len)));
      hit_raw = ((hist_n ^ pattern) & mask) == '0;
   end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial bit-pattern detector with saturating match counter
module seq_detector_prog
   import seq_detector_prog_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x,
   input  logic               x_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err,
   output logic               armed
);

   localparam int FILL_W = $clog2(MAX_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

   state_e               state_q, state_d;
   // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
   logic [MAX_LEN-2:0]   history_q, history_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [MAX_LEN-1:0]   pattern_q, pattern_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 overlap_q, overlap_d;
   logic                 z_q, z_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 armed_q, armed_d;

   logic [MAX_LEN-1:0]   hist_n;
   logic [FILL_W-1:0]    fill_n;
   logic                 sample;
   logic                 hit_raw;
   logic                 hit;
   logic                 new_len_ok;

   seq_mask_cmp #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_mask_cmp (
      .hist_n  (hist_n),
      .pattern (pattern_q),
      .len     (len_q),
      .hit_raw (hit_raw)
   );

   always_comb begin
      hist_n     = {history_q, x};
      fill_n     = (fill_q >= FILL_MAX) ? fill_q : fill_q + 1'b1;
      sample     = (state_q == ST_HUNT) && x_valid && !cfg_load;
      hit        = sample && (32'(fill_n) >= 32'(len_q)) && hit_raw;
      new_len_ok = len_legal(32'(cfg_len), MAX_LEN);
   end

   always_comb begin
      state_d   = state_q;
      history_d = history_q;
      fill_d    = fill_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      cfg_err_d = cfg_err_q;
      z_d       = 1'b0;
      cnt_d     = cnt_q;

      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         history_d = '0;
         fill_d    = '0;
         cfg_err_d = !new_len_ok;
         state_d   = new_len_ok ? ST_HUNT : ST_IDLE;
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (sample) begin
                  history_d = hist_n[MAX_LEN-2:0];
                  fill_d    = fill_n;
                  z_d       = hit;
                  // Non-overlapping: restart the fill so no matched bit is reused.
                  if (hit && !overlap_q) begin
                     fill_d = '0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end

      armed_d = (state_d == ST_HUNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         history_q <= '0;
         fill_q    <= '0;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         z_q       <= 1'b0;
         cnt_q     <= '0;
         cfg_err_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         history_q <= history_d;
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         z_q       <= z_d;
         cnt_q     <= cnt_d;
         cfg_err_q <= cfg_err_d;
         armed_q   <= armed_d;
      end
   end

   assign z         = z_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = cfg_err_q;
   assign armed     = armed_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - self-checking bench with a queue-based reference model and directed vectors
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = 7;

   logic               clk;
   logic               rst;
   logic               x;
   logic               x_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               z;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;
   logic               armed;

   int n_cmp = 0;
   int n_bad = 0;

   seq_detector_prog #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .x           (x),
      .x_valid     (x_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .z           (z),
      .match_cnt   (match_cnt),
      .cfg_err     (cfg_err),
      .armed       (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: bits seen since the last (re)start, matched against the pattern end-first.
   bit          m_started = 0;
   bit          m_hunt;
   logic [7:0]  m_pat;
   int          m_len;
   bit          m_ov;
   bit          m_z;
   int          m_cnt;
   bit          m_err;
   bit          m_bits[$];

   always @(posedge clk) begin
      bit hit;
      m_started = 1;
      hit = 0;
      if (rst) begin
         m_hunt = 0; m_pat = '0; m_len = 0; m_ov = 0;
         m_z = 0; m_cnt = 0; m_err = 0;
         m_bits.delete();
      end else begin
         if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            m_ov  = cfg_overlap;
            m_bits.delete();
            m_err  = !(m_len >= 1 && m_len <= MAX_LEN);
            m_hunt = !m_err;
         end else if (m_hunt && x_valid) begin
            m_bits.push_back(x);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
               hit = 1;
               for (int i = 0; i < m_len; i++)
                  if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            if (hit && !m_ov) m_bits.delete();
         end
         m_z = hit;
         if (cnt_clr) m_cnt = 0;
         else if (hit && m_cnt < CNT_MAX) m_cnt++;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("cyc_z",       32'(z),         32'(m_z));
         chk("cyc_cnt",     32'(match_cnt), 32'(m_cnt));
         chk("cyc_armed",   32'(armed),     32'(m_hunt));
         chk("cyc_cfg_err", 32'(cfg_err),   32'(m_err));
      end
   end

   task automatic cyc(input logic xi, input logic xv, input logic clr = 1'b0);
      x = xi; x_valid = xv; cnt_clr = clr;
      @(posedge clk); #1;
      x_valid = 1'b0; cnt_clr = 1'b0;
   endtask

   // x is held valid on the load cycle to show it is ignored.
   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic clr);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      cfg_load = 1'b1; cnt_clr = clr; x = 1'b1; x_valid = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0; cnt_clr = 1'b0; x_valid = 1'b0;
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1);
   endtask

   initial begin
      rst = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
      cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_z", 32'(z), 0);
      chk("rst_cnt", 32'(match_cnt), 0);
      chk("rst_armed", 32'(armed), 0);
      chk("rst_err", 32'(cfg_err), 0);

      // 1000, overlapping
      load(8'h08, 4'd4, 1'b1, 1'b0);
      chk("t1_armed", 32'(armed), 1);
      stream(16'b100, 3);
      chk("t1_z_early", 32'(z), 0);
      cyc(1'b0, 1'b1);
      chk("t1_z", 32'(z), 1);
      chk("t1_cnt", 32'(match_cnt), 1);
      cyc(1'b0, 1'b1);
      chk("t1_z_once", 32'(z), 0);

      // 101 with junk above len, overlapping then not
      load(8'hFD, 4'd3, 1'b1, 1'b1);
      chk("t2_clr", 32'(match_cnt), 0);
      stream(16'b101, 3);
      chk("t2_ov_z3", 32'(z), 1);
      stream(16'b01, 2);
      chk("t2_ov_z5", 32'(z), 1);
      chk("t2_ov_cnt", 32'(match_cnt), 2);
      load(8'hFD, 4'd3, 1'b0, 1'b1);
      stream(16'b101, 3);
      chk("t2_nov_z3", 32'(z), 1);
      stream(16'b01, 2);
      chk("t2_nov_z5", 32'(z), 0);
      chk("t2_nov_cnt", 32'(match_cnt), 1);

      // 11 across an x_valid gap
      load(8'h03, 4'd2, 1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      chk("t3_gap_z", 32'(z), 0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      chk("t3_z", 32'(z), 1);
      chk("t3_cnt", 32'(match_cnt), 1);

      // illegal lengths
      load(8'h07, 4'd0, 1'b1, 1'b0);
      chk("t4_err0", 32'(cfg_err), 1);
      chk("t4_armed0", 32'(armed), 0);
      stream(16'b111, 3);
      chk("t4_z0", 32'(z), 0);
      load(8'h07, 4'd9, 1'b1, 1'b0);
      chk("t4_err9", 32'(cfg_err), 1);
      stream(16'b111, 3);
      chk("t4_z9", 32'(z), 0);
      load(8'h07, 4'd3, 1'b1, 1'b0);
      chk("t4_err3", 32'(cfg_err), 0);
      chk("t4_armed3", 32'(armed), 1);
      stream(16'b111, 3);
      chk("t4_z3", 32'(z), 1);

      // full-width pattern
      load(8'hB3, 4'd8, 1'b0, 1'b1);
      stream(16'b1011001, 7);
      chk("t4b_z7", 32'(z), 0);
      cyc(1'b1, 1'b1);
      chk("t4b_z8", 32'(z), 1);
      chk("t4b_cnt", 32'(match_cnt), 1);

      // saturation and clear priority
      load(8'h01, 4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
      chk("t5_sat", 32'(match_cnt), 7);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t5_clr_cnt", 32'(match_cnt), 0);
      chk("t5_clr_z", 32'(z), 1);

      // reset mid-stream
      load(8'h08, 4'd4, 1'b1, 1'b1);
      stream(16'b10, 2);
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      chk("t6_z", 32'(z), 0);
      chk("t6_cnt", 32'(match_cnt), 0);
      chk("t6_armed", 32'(armed), 0);
      chk("t6_err", 32'(cfg_err), 0);
      stream(16'b00, 2);
      chk("t6_noload_z", 32'(z), 0);
      load(8'h08, 4'd4, 1'b1, 1'b0);
      stream(16'b00, 2);
      chk("t6_reload_z", 32'(z), 0);
      stream(16'b1000, 4);
      chk("t6_after_z", 32'(z), 1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It supports a configurable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, and gating of the input bit by a valid strobe. A saturating match counter is included. It sits on the serial data path after the bit-level front end and signals matches to control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, 4, width of cfg_len; must hold MAX_LEN.
CNT_W, 8, width of match_cnt.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
x  in  1  serial input bit.
x_valid  in  1  x is sampled only on cycles where this is 1.
cfg_load  in  1  one-cycle strobe that latches the cfg_* inputs.
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
cfg_len  in  LEN_W  pattern length; legal values are 1..MAX_LEN.
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
cnt_clr  in  1  clears match_cnt.
z  out  1  registered one-cycle match pulse.
match_cnt  out  CNT_W  saturating count of matches.
cfg_err  out  1  latched cfg_len is illegal.
armed  out  1  FSM is in HUNT.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - z=0, match_cnt=0, armed=0, cfg_err=0.
  - Internal state: history=0, fill=0, pattern=0, len=0, overlap=0, state IDLE.
- Clock-to-output paths: z, match_cnt, armed and cfg_err are all registers. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, HUNT.
  - IDLE: no detection. On cfg_load with a legal cfg_len, go to HUNT. On cfg_load with an illegal cfg_len (0 or >MAX_LEN), stay in IDLE and set cfg_err=1.
  - HUNT: detection is active. On cfg_load, relatch config and then follow the IDLE rules for the new cfg_len, so an illegal length returns the FSM to IDLE.
- Effect of cfg_load in any state:
  - Latches pattern, len and overlap.
  - Clears history, fill and z.
  - Sets cfg_err to the legality of the new length.
  - x is ignored on the cfg_load cycle.
- Sampling in HUNT, on a cycle with x_valid=1 and cfg_load=0:
  - hist_n = {history[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
  - hit = (fill_n >= len) and (hist_n[len-1:0] == pattern[len-1:0]).
- Update on hit:
  - z is 1 on the next cycle, for exactly one cycle.
  - history <= hist_n.
  - fill <= fill_n when overlap=1; fill <= 0 when overlap=0, so no bit of the match is reused.
- Update on no hit: history <= hist_n, fill <= fill_n, z <= 0.
- Cycles with x_valid=0: history and fill hold; z <= 0. Gaps in x_valid do not break a partial match.
- Latency: z rises one clock after the edge that samples the final pattern bit.
- match_cnt:
  - Increments by 1 on each hit and saturates at 2^CNT_W-1.
  - cnt_clr has priority: if cnt_clr and a hit occur in the same cycle, match_cnt becomes 0.
  - cnt_clr does not affect z.
- Mask rule: bits of cfg_pattern at or above len are don't-care.
- len=MAX_LEN: the whole history register is compared.
- Reset mid-stream: all state returns to reset values. The detector must be reconfigured with cfg_load before it detects again.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, HUNT).
  - Function len_legal(len, MAX_LEN).
  - Function len_mask(len) returning the MAX_LEN-bit mask ((1<<len)-1).
- Sub-module seq_mask_cmp: combinational masked compare of hist_n against pattern using len_mask. Parameter MAX_LEN; output hit_raw.
- The top level holds the FSM, history, fill and counter.

Test Plan:
1. cfg 1000, len=4, overlap=1; stream 1,0,0,0,0 -> exactly one z pulse, one cycle after the 4th bit; match_cnt=1.
2. cfg 101, len=3; stream 1,0,1,0,1 -> overlap=1 gives z after bits 3 and 5 (match_cnt=2); overlap=0 gives z after bit 3 only (match_cnt=1).
3. cfg 11, len=2; x_valid pattern 1,0,0,1 with x=1 throughout -> z one cycle after the 4th cycle; no z during gap cycles.
4. cfg_len=0, then 9 (MAX_LEN=8) -> cfg_err=1, armed=0, no z for any stream. Then cfg_len=3 -> cfg_err=0, armed=1.
5. CNT_W=3, cfg 1, len=1, ten valid 1-bits -> match_cnt stops at 7. cnt_clr asserted on a hit cycle -> match_cnt=0.
6. rst asserted after 2 bits of 1000, then cfg reloaded and stream 0,0 -> no match; all outputs are 0 the cycle after rst.
